// File: rtl/riscv_bp_pkg.sv
// rtl/riscv_bp_pkg.sv - shared types and helpers for the branch predictor
package riscv_bp_pkg;

    typedef enum logic [1:0] {
        BR  = 2'd0,
        JAL = 2'd1,
        JMP = 2'd2,
        RET = 2'd3
    } btb_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == CTR_ST) ? CTR_ST : c + 2'b01;
        return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and execute resolution bus
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic            ex_rd_link;
    logic            ex_rs1_link;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_rd_link, ex_rs1_link, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_rd_link, ex_rs1_link, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/bp_ras.sv
// rtl/bp_ras.sv - circular return-address stack, overwrites oldest entry when full
module bp_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] wrap_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign top_ptr = wrap_dec(ptr);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            ptr <= wrap_inc(ptr);
            if (!full)
                count <= count + 1'b1;
        end else if (do_pop && !push) begin
            ptr   <= top_ptr;
            count <= count - 1'b1;
        end
    end

    // Pop+push on a non-empty stack rewrites the top slot in place.
    always_ff @(posedge clk) begin
        if (push)
            mem[do_pop ? top_ptr : ptr] <= push_data;
    end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and a RAS
module branch_predictor
    import riscv_bp_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BTB_ENTRIES = 16,
    parameter int         RAS_DEPTH   = 4,
    parameter logic [1:0] CNT_INIT    = CTR_WNT
) (
    input  logic             clk,
    input  logic             rst,
    branch_predictor_if.slave bp
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic            btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];
    btb_type_e       btb_type   [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]  f_idx;
    logic            f_hit;
    logic [IDX-1:0]  e_idx;
    logic [TAG_W-1:0] e_tag;
    logic            e_hit_br;
    logic            cf_valid;
    btb_type_e       alloc_type;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_push;
    logic            ras_pop;
    logic [31:0]     perf_br;
    logic [31:0]     perf_mp;

    assign f_idx = bp.if_pc[IDX+1:2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == bp.if_pc[XLEN-1:IDX+2]);

    always_comb begin
        bp.pred_taken  = 1'b0;
        bp.pred_target = bp.if_pc + XLEN'(4);
        if (f_hit) begin
            case (btb_type[f_idx])
                BR: if (btb_ctr[f_idx][1]) begin
                    bp.pred_taken  = 1'b1;
                    bp.pred_target = btb_target[f_idx];
                end
                JAL, JMP: begin
                    bp.pred_taken  = 1'b1;
                    bp.pred_target = btb_target[f_idx];
                end
                RET: begin
                    bp.pred_taken  = 1'b1;
                    bp.pred_target = ras_empty ? btb_target[f_idx] : ras_top;
                end
                default: ;
            endcase
        end
    end

    assign cf_valid = bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jal || bp.ex_is_jalr);
    assign e_idx    = bp.ex_pc[IDX+1:2];
    assign e_tag    = bp.ex_pc[XLEN-1:IDX+2];
    assign e_hit_br = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag) && (btb_type[e_idx] == BR);

    always_comb begin
        alloc_type = BR;
        if (bp.ex_is_jal)
            alloc_type = JAL;
        else if (bp.ex_is_jalr)
            alloc_type = (bp.ex_rs1_link && !bp.ex_rd_link) ? RET : JMP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_type[i]   <= BR;
                btb_ctr[i]    <= CNT_INIT;
            end
        end else if (cf_valid) begin
            if (bp.ex_is_branch && e_hit_br) begin
                btb_ctr[e_idx]    <= ctr_next(btb_ctr[e_idx], bp.ex_taken);
                btb_target[e_idx] <= bp.ex_target;
            end else if (!bp.ex_is_branch || bp.ex_taken) begin
                btb_valid[e_idx]  <= 1'b1;
                btb_tag[e_idx]    <= e_tag;
                btb_target[e_idx] <= bp.ex_target;
                btb_type[e_idx]   <= alloc_type;
                btb_ctr[e_idx]    <= CTR_WT;
            end
        end
    end

    // Only link flags reach us, so a JALR with both links is treated as rd != rs1.
    assign ras_push = cf_valid && (bp.ex_is_jal || bp.ex_is_jalr) && bp.ex_rd_link;
    assign ras_pop  = cf_valid && bp.ex_is_jalr && bp.ex_rs1_link;

    bp_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (bp.ex_pc + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    assign bp.mispredict  = cf_valid && ((bp.ex_taken != bp.ex_pred_taken) ||
                            (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_br <= '0;
            perf_mp <= '0;
        end else if (cf_valid) begin
            if (perf_br != '1)
                perf_br <= perf_br + 1'b1;
            if (bp.mispredict && perf_mp != '1)
                perf_mp <= perf_mp + 1'b1;
        end
    end

    assign bp.perf_branches    = perf_br;
    assign bp.perf_mispredicts = perf_mp;
endmodule
